// File: rtl/ann_param_loader.sv
// ann_param_loader: streams parameter bytes over a valid/ready handshake into
// the four flat parameter buses consumed by the FP ANN equaliser. Sections are
// filled in fixed order W1 -> B1 -> W2 -> B2, and params_valid is raised once
// a complete, ordered set has been written.
module ann_param_loader #(
  parameter int unsigned MAIN_TAP         = 28,
  parameter int unsigned TOTAL_TAP        = 84,
  parameter int unsigned INPUT_DATA_WIDTH = 8,
  parameter int unsigned N_HIDDEN         = 96
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          load_start,
  input  logic                                          load_abort,
  input  logic [INPUT_DATA_WIDTH-1:0]                   s_data,
  input  logic                                          s_valid,
  output logic                                          s_ready,
  output logic [INPUT_DATA_WIDTH*TOTAL_TAP*N_HIDDEN-1:0] weight_input_to_hidden,
  output logic [INPUT_DATA_WIDTH*N_HIDDEN-1:0]          bias_hidden,
  output logic [INPUT_DATA_WIDTH*N_HIDDEN*MAIN_TAP-1:0] weight_hidden_to_output,
  output logic [INPUT_DATA_WIDTH*MAIN_TAP-1:0]          bias_output,
  output logic                                          busy,
  output logic                                          load_done,
  output logic                                          params_valid
);

  localparam int unsigned DW    = INPUT_DATA_WIDTH;
  localparam int unsigned NW1   = TOTAL_TAP * N_HIDDEN;
  localparam int unsigned NB1   = N_HIDDEN;
  localparam int unsigned NW2   = N_HIDDEN * MAIN_TAP;
  localparam int unsigned NB2   = MAIN_TAP;
  localparam int unsigned CNT_W = $clog2(NW1);

  localparam int unsigned W1_BITS = DW * NW1;
  localparam int unsigned B1_BITS = DW * NB1;
  localparam int unsigned W2_BITS = DW * NW2;
  localparam int unsigned B2_BITS = DW * NB2;

  // Bit-offset widths sized exactly to each bus so part-selects stay in range.
  localparam int unsigned IW1 = $clog2(W1_BITS);
  localparam int unsigned IB1 = $clog2(B1_BITS);
  localparam int unsigned IW2 = $clog2(W2_BITS);
  localparam int unsigned IB2 = $clog2(B2_BITS);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_W1 = 3'd1,
    ST_LOAD_B1 = 3'd2,
    ST_LOAD_W2 = 3'd3,
    ST_LOAD_B2 = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  state_t             w_sect_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_loading;
  logic               w_next_loading;
  logic               w_xfer;
  logic               w_last;
  logic               w_wr_en;

  logic               r_s_ready;
  logic               r_busy;
  logic               r_load_done;
  logic               r_params_valid;

  logic [W1_BITS-1:0] r_w1;
  logic [B1_BITS-1:0] r_b1;
  logic [W2_BITS-1:0] r_w2;
  logic [B2_BITS-1:0] r_b2;

  logic [IW1-1:0]     w_idx_w1;
  logic [IB1-1:0]     w_idx_b1;
  logic [IW2-1:0]     w_idx_w2;
  logic [IB2-1:0]     w_idx_b2;

  // Handshake qualifiers; s_ready is registered and mirrors the LOAD states.
  always_comb begin
    w_loading = (r_state == ST_LOAD_W1) || (r_state == ST_LOAD_B1) ||
                (r_state == ST_LOAD_W2) || (r_state == ST_LOAD_B2);
    w_xfer    = s_valid && r_s_ready;
  end

  // Per-section last-byte detection and the section that follows it.
  always_comb begin
    w_last      = 1'b0;
    w_sect_next = ST_IDLE;
    case (r_state)
      ST_LOAD_W1: begin
        w_last      = (r_cnt == CNT_W'(NW1 - 1));
        w_sect_next = ST_LOAD_B1;
      end
      ST_LOAD_B1: begin
        w_last      = (r_cnt == CNT_W'(NB1 - 1));
        w_sect_next = ST_LOAD_W2;
      end
      ST_LOAD_W2: begin
        w_last      = (r_cnt == CNT_W'(NW2 - 1));
        w_sect_next = ST_LOAD_B2;
      end
      ST_LOAD_B2: begin
        w_last      = (r_cnt == CNT_W'(NB2 - 1));
        w_sect_next = ST_DONE;
      end
      default: begin
        w_last      = 1'b0;
        w_sect_next = ST_IDLE;
      end
    endcase
  end

  // Next-state, counter and write-enable; abort beats a same-cycle transfer.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_wr_en      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load_start) begin
          w_state_next = ST_LOAD_W1;
          w_cnt_next   = '0;
        end
      end
      ST_LOAD_W1, ST_LOAD_B1, ST_LOAD_W2, ST_LOAD_B2: begin
        if (load_abort) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else if (w_xfer) begin
          w_wr_en = 1'b1;
          if (w_last) begin
            w_state_next = w_sect_next;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
    w_next_loading = (w_state_next == ST_LOAD_W1) || (w_state_next == ST_LOAD_B1) ||
                     (w_state_next == ST_LOAD_W2) || (w_state_next == ST_LOAD_B2);
  end

  // State and byte counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Status outputs registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s_ready      <= 1'b0;
      r_busy         <= 1'b0;
      r_load_done    <= 1'b0;
      r_params_valid <= 1'b0;
    end else begin
      r_s_ready   <= w_next_loading;
      r_busy      <= w_next_loading;
      r_load_done <= (w_state_next == ST_DONE);
      // Cleared at start, so an aborted load leaves it low.
      if ((r_state == ST_IDLE) && load_start) begin
        r_params_valid <= 1'b0;
      end else if (w_state_next == ST_DONE) begin
        r_params_valid <= 1'b1;
      end
    end
  end

  // Bit offset of the addressed byte within each section bus.
  always_comb begin
    w_idx_w1 = IW1'(r_cnt * DW);
    w_idx_b1 = IB1'(r_cnt * DW);
    w_idx_w2 = IW2'(r_cnt * DW);
    w_idx_b2 = IB2'(r_cnt * DW);
  end

  // Parameter storage: only the addressed byte of the active section changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_w1 <= '0;
      r_b1 <= '0;
      r_w2 <= '0;
      r_b2 <= '0;
    end else if (w_wr_en) begin
      case (r_state)
        ST_LOAD_W1: r_w1[w_idx_w1 +: DW] <= s_data;
        ST_LOAD_B1: r_b1[w_idx_b1 +: DW] <= s_data;
        ST_LOAD_W2: r_w2[w_idx_w2 +: DW] <= s_data;
        ST_LOAD_B2: r_b2[w_idx_b2 +: DW] <= s_data;
        default: ;
      endcase
    end
  end

  assign s_ready                 = r_s_ready;
  assign busy                    = r_busy;
  assign load_done               = r_load_done;
  assign params_valid            = r_params_valid;
  assign weight_input_to_hidden  = r_w1;
  assign bias_hidden             = r_b1;
  assign weight_hidden_to_output = r_w2;
  assign bias_output             = r_b2;

endmodule

// File: tb/tb_ann_param_loader.sv
// Directed testbench for ann_param_loader: full loads, stalled stream,
// ignored start, abort on W2 byte 100 and reset during a load.
module tb_ann_param_loader;

  localparam int DW     = 8;
  localparam int NW1    = 8064;
  localparam int NB1    = 96;
  localparam int NW2    = 2688;
  localparam int NB2    = 28;
  localparam int NTOT   = 10876;
  localparam int B1_OFF = 8064;
  localparam int W2_OFF = 8160;
  localparam int B2_OFF = 10848;

  logic clk = 1'b0;
  logic reset;
  logic load_start;
  logic load_abort;
  logic [DW-1:0] s_data;
  logic s_valid;
  logic s_ready;
  logic [DW*NW1-1:0] w1;
  logic [DW*NB1-1:0] b1;
  logic [DW*NW2-1:0] w2;
  logic [DW*NB2-1:0] b2;
  logic busy;
  logic load_done;
  logic params_valid;

  logic [7:0] exp_mem [NTOT];
  int n_checks = 0;
  int n_pass   = 0;
  int done_pulses = 0;

  ann_param_loader dut (
    .clk                     (clk),
    .reset                   (reset),
    .load_start              (load_start),
    .load_abort              (load_abort),
    .s_data                  (s_data),
    .s_valid                 (s_valid),
    .s_ready                 (s_ready),
    .weight_input_to_hidden  (w1),
    .bias_hidden             (b1),
    .weight_hidden_to_output (w2),
    .bias_output             (b2),
    .busy                    (busy),
    .load_done               (load_done),
    .params_valid            (params_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (load_done === 1'b1) done_pulses++;

  // Byte at global stream index g, read from whichever bus holds it.
  function automatic logic [7:0] bus_byte(input int g);
    if (g < B1_OFF)      return 8'(w1 >> (8 * g));
    else if (g < W2_OFF) return 8'(b1 >> (8 * (g - B1_OFF)));
    else if (g < B2_OFF) return 8'(w2 >> (8 * (g - W2_OFF)));
    else                 return 8'(b2 >> (8 * (g - B2_OFF)));
  endfunction

  function automatic int bus_errs();
    int n = 0;
    for (int g = 0; g < NTOT; g++) if (bus_byte(g) !== exp_mem[g]) n++;
    return n;
  endfunction

  task automatic start_pulse();
    @(negedge clk);
    load_start = 1'b1;
    s_valid    = 1'b0;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Sends n bytes starting at global index first; byte k carries (base+k) mod 256.
  task automatic stream(input int first, input int n, input int base, input bit stalls);
    int got = 0;
    int cyc = 0;
    bit xfer;
    while (got < n && cyc < 40000) begin
      @(negedge clk);
      s_valid = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data  = 8'(base + first + got);
      xfer    = s_valid && s_ready;
      @(posedge clk);
      if (xfer) begin
        exp_mem[first + got] = s_data;
        got++;
      end
      cyc++;
    end
    n_checks++;
    if (got != n) $display("FAIL stream_budget: accepted %0d required %0d", got, n);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_start = 1'b0; load_abort = 1'b0; s_valid = 1'b0; s_data = '0;
    for (int i = 0; i < NTOT; i++) exp_mem[i] = 8'h00;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    n_checks++; if (w1 !== '0) $display("FAIL reset_w1: got nonzero want 0"); else n_pass++;
    n_checks++; if (b1 !== '0) $display("FAIL reset_b1: got %h want 0", b1); else n_pass++;
    n_checks++; if (w2 !== '0) $display("FAIL reset_w2: got nonzero want 0"); else n_pass++;
    n_checks++; if (b2 !== '0) $display("FAIL reset_b2: got %h want 0", b2); else n_pass++;
    n_checks++; if ({s_ready, busy, params_valid, load_done} !== 4'b0000)
      $display("FAIL reset_status: got %b want 0000", {s_ready, busy, params_valid, load_done});
    else n_pass++;
  endtask

  task automatic test_full_load();
    int d0 = done_pulses;
    start_pulse();
    n_checks++; if ({s_ready, busy, params_valid} !== 3'b110)
      $display("FAIL full_start: got %b want 110", {s_ready, busy, params_valid}); else n_pass++;
    stream(0, NTOT, 0, 1'b0);
    @(negedge clk); s_valid = 1'b0;
    n_checks++; if ({load_done, params_valid, s_ready, busy} !== 4'b1100)
      $display("FAIL full_done_cycle: got %b want 1100", {load_done, params_valid, s_ready, busy});
    else n_pass++;
    @(negedge clk);
    n_checks++; if ({load_done, params_valid, busy} !== 3'b010)
      $display("FAIL full_after_done: got %b want 010", {load_done, params_valid, busy}); else n_pass++;
    n_checks++; if (done_pulses - d0 !== 1)
      $display("FAIL full_done_pulses: got %0d want 1", done_pulses - d0); else n_pass++;
    n_checks++; if (bus_byte(0) !== 8'h00) $display("FAIL w1_b0: got %h want 00", bus_byte(0)); else n_pass++;
    n_checks++; if (bus_byte(8063) !== 8'h7F) $display("FAIL w1_b8063: got %h want 7f", bus_byte(8063)); else n_pass++;
    n_checks++; if (bus_byte(B1_OFF) !== 8'h80) $display("FAIL b1_b0: got %h want 80", bus_byte(B1_OFF)); else n_pass++;
    n_checks++; if (bus_byte(W2_OFF) !== 8'hE0) $display("FAIL w2_b0: got %h want e0", bus_byte(W2_OFF)); else n_pass++;
    n_checks++; if (bus_byte(B2_OFF) !== 8'h60) $display("FAIL b2_b0: got %h want 60", bus_byte(B2_OFF)); else n_pass++;
    n_checks++; if (bus_byte(B2_OFF + 27) !== 8'h7B) $display("FAIL b2_b27: got %h want 7b", bus_byte(B2_OFF + 27)); else n_pass++;
    n_checks++; if (bus_errs() !== 0) $display("FAIL full_buses: got %0d bad bytes want 0", bus_errs()); else n_pass++;
  endtask

  task automatic test_abort();
    int d0;
    start_pulse();
    n_checks++; if (params_valid !== 1'b0) $display("FAIL abort_pv_cleared: got %b want 0", params_valid); else n_pass++;
    stream(0, W2_OFF + 100, 5, 1'b0);
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'hAA; load_abort = 1'b1;
    @(negedge clk);
    load_abort = 1'b0; s_valid = 1'b0;
    n_checks++; if ({s_ready, busy, params_valid} !== 3'b000)
      $display("FAIL abort_status: got %b want 000", {s_ready, busy, params_valid}); else n_pass++;
    n_checks++; if (bus_byte(W2_OFF + 99) !== 8'h48) $display("FAIL abort_w2_b99: got %h want 48", bus_byte(W2_OFF + 99)); else n_pass++;
    n_checks++; if (bus_byte(W2_OFF + 100) !== 8'h44) $display("FAIL abort_w2_b100: got %h want 44", bus_byte(W2_OFF + 100)); else n_pass++;
    n_checks++; if (bus_errs() !== 0) $display("FAIL abort_buses: got %0d bad bytes want 0", bus_errs()); else n_pass++;
    d0 = done_pulses;
    start_pulse();
    stream(0, NTOT, 3, 1'b0);
    @(negedge clk); s_valid = 1'b0;
    n_checks++; if ({load_done, params_valid} !== 2'b11)
      $display("FAIL fresh_done: got %b want 11", {load_done, params_valid}); else n_pass++;
    @(negedge clk);
    n_checks++; if (done_pulses - d0 !== 1) $display("FAIL fresh_pulses: got %0d want 1", done_pulses - d0); else n_pass++;
    n_checks++; if (bus_byte(0) !== 8'h03) $display("FAIL fresh_w1_b0: got %h want 03", bus_byte(0)); else n_pass++;
    n_checks++; if (bus_errs() !== 0) $display("FAIL fresh_buses: got %0d bad bytes want 0", bus_errs()); else n_pass++;
  endtask

  task automatic test_stall_and_start();
    int d0 = done_pulses;
    start_pulse();
    stream(0, B1_OFF + 40, 0, 1'b1);
    @(negedge clk);
    load_start = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    load_start = 1'b0;
    n_checks++; if ({s_ready, busy, params_valid} !== 3'b110)
      $display("FAIL midstart_ignored: got %b want 110", {s_ready, busy, params_valid}); else n_pass++;
    stream(B1_OFF + 40, NTOT - (B1_OFF + 40), 0, 1'b1);
    n_checks++; if (done_pulses - d0 !== 0) $display("FAIL stall_early_done: got %0d want 0", done_pulses - d0); else n_pass++;
    @(negedge clk); s_valid = 1'b0;
    n_checks++; if ({load_done, params_valid} !== 2'b11)
      $display("FAIL stall_done: got %b want 11", {load_done, params_valid}); else n_pass++;
    @(negedge clk);
    n_checks++; if (done_pulses - d0 !== 1) $display("FAIL stall_pulses: got %0d want 1", done_pulses - d0); else n_pass++;
    n_checks++; if (bus_byte(B1_OFF) !== 8'h80) $display("FAIL stall_b1_b0: got %h want 80", bus_byte(B1_OFF)); else n_pass++;
    n_checks++; if (bus_errs() !== 0) $display("FAIL stall_buses: got %0d bad bytes want 0", bus_errs()); else n_pass++;
  endtask

  task automatic test_idle_ignore();
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'hFF; load_abort = 1'b1;
    @(negedge clk); @(negedge clk);
    s_valid = 1'b0; load_abort = 1'b0;
    n_checks++; if ({busy, params_valid} !== 2'b01)
      $display("FAIL idle_status: got %b want 01", {busy, params_valid}); else n_pass++;
    n_checks++; if (bus_errs() !== 0) $display("FAIL idle_buses: got %0d bad bytes want 0", bus_errs()); else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    int d0;
    @(negedge clk);
    load_start = 1'b1; load_abort = 1'b1;
    @(negedge clk);
    load_start = 1'b0; load_abort = 1'b0;
    n_checks++; if ({s_ready, busy} !== 2'b11) $display("FAIL start_beats_abort: got %b want 11", {s_ready, busy}); else n_pass++;
    stream(0, W2_OFF + 50, 9, 1'b0);
    @(negedge clk);
    reset = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NTOT; i++) exp_mem[i] = 8'h00;
    n_checks++; if ({s_ready, busy, params_valid, load_done} !== 4'b0000)
      $display("FAIL midreset_status: got %b want 0000", {s_ready, busy, params_valid, load_done}); else n_pass++;
    n_checks++; if (bus_errs() !== 0) $display("FAIL midreset_buses: got %0d bad bytes want 0", bus_errs()); else n_pass++;
    d0 = done_pulses;
    start_pulse();
    stream(0, NTOT, 0, 1'b0);
    @(negedge clk); s_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({params_valid, done_pulses - d0} !== {1'b1, 32'sd1})
      $display("FAIL reload_done: got pv=%b pulses=%0d want pv=1 pulses=1", params_valid, done_pulses - d0); else n_pass++;
    n_checks++; if (bus_byte(B2_OFF + 27) !== 8'h7B) $display("FAIL reload_b2_b27: got %h want 7b", bus_byte(B2_OFF + 27)); else n_pass++;
    n_checks++; if (bus_errs() !== 0) $display("FAIL reload_buses: got %0d bad bytes want 0", bus_errs()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_abort();
    test_stall_and_start();
    test_idle_ignore();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
    $fatal(1);
  end

endmodule
